// File: rtl/alu2_seq.sv
// alu2_seq: runs one WIDTH-bit ALU operation through an external 2-bit alu2 slice,
// streaming operand bit pairs LSB first and assembling the result word beat by beat.
module alu2_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic             rx_valid,
    output logic             tx_ready,
    input  logic [5:0]       rx_op,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_operand0,
    input  logic [WIDTH-1:0] rx_operand1,
    output logic             tx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] tx_result,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_signflag,
    output logic             tx_error,
    output logic [5:0]       tx_slice_op,
    output logic             tx_slice_carryflag,
    output logic [1:0]       tx_slice_operand0,
    output logic [1:0]       tx_slice_operand1,
    input  logic [1:0]       rx_slice_result,
    input  logic             rx_slice_carryflag
);

    localparam int unsigned BEATS = WIDTH / 2;
    localparam int unsigned KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic [KW-1:0]      k_q, k_d;
    logic               op_onehot;

    assign op_onehot = (rx_op != 6'd0) && ((rx_op & (rx_op - 6'd1)) == 6'd0);

    // Next-state: accept a request, run one beat per cycle, hold the result until taken.
    // carry_q doubles as carry-in register: loaded with the request carry, then chained.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    op_d    = rx_op;
                    a_d     = rx_operand0;
                    b_d     = rx_operand1;
                    res_d   = '0;
                    k_d     = '0;
                    err_d   = ~op_onehot;
                    carry_d = op_onehot ? rx_carryflag : 1'b0;
                    state_d = op_onehot ? StRun : StDone;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < BEATS; i++) begin
                    if (k_q == KW'(i)) res_d[2*i +: 2] = rx_slice_result;
                end
                carry_d = rx_slice_carryflag;
                if (k_q == KW'(BEATS - 1)) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                if (rx_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            k_q     <= k_d;
        end
    end

    // Slice drive: only active during RUN, otherwise held at zero.
    always_comb begin
        tx_slice_op        = 6'd0;
        tx_slice_carryflag = 1'b0;
        tx_slice_operand0  = 2'd0;
        tx_slice_operand1  = 2'd0;
        if (state_q == StRun) begin
            tx_slice_op        = op_q;
            tx_slice_carryflag = carry_q;
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (k_q == KW'(i)) begin
                    tx_slice_operand0 = a_q[2*i +: 2];
                    tx_slice_operand1 = b_q[2*i +: 2];
                end
            end
        end
    end

    // Consumer-facing outputs come straight from registered state.
    always_comb begin
        tx_ready     = (state_q == StIdle);
        tx_valid     = (state_q == StDone);
        tx_result    = res_q;
        tx_carryflag = carry_q;
        tx_error     = err_q;
        tx_zeroflag  = ~|res_q;
        tx_signflag  = res_q[WIDTH-1];
    end

endmodule

// File: tb/tb_alu2_seq.sv
// tb_alu2_seq: table-driven check of alu2_seq against a behavioural 2-bit slice.
module tb_alu2_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid, tx_ready, tx_valid, rx_ready;
    logic [5:0]  rx_op, s_op;
    logic        rx_cin;
    logic [15:0] rx_a, rx_b, tx_result;
    logic        tx_c, tx_z, tx_s, tx_err;
    logic        s_cin, s_cout;
    logic [1:0]  s_a, s_b, s_res;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu2_seq #(.WIDTH(16)) dut (
        .rx_clk             (clk),
        .rx_rst_n           (rst_n),
        .rx_valid           (rx_valid),
        .tx_ready           (tx_ready),
        .rx_op              (rx_op),
        .rx_carryflag       (rx_cin),
        .rx_operand0        (rx_a),
        .rx_operand1        (rx_b),
        .tx_valid           (tx_valid),
        .rx_ready           (rx_ready),
        .tx_result          (tx_result),
        .tx_carryflag       (tx_c),
        .tx_zeroflag        (tx_z),
        .tx_signflag        (tx_s),
        .tx_error           (tx_err),
        .tx_slice_op        (s_op),
        .tx_slice_carryflag (s_cin),
        .tx_slice_operand0  (s_a),
        .tx_slice_operand1  (s_b),
        .rx_slice_result    (s_res),
        .rx_slice_carryflag (s_cout)
    );

    // Behavioural alu2 slice: add, sub (a + ~b + cin), rot (swap bit pair), and, or, xor.
    always_comb begin
        s_res  = 2'd0;
        s_cout = 1'b0;
        case (s_op)
            6'b000001: {s_cout, s_res} = {1'b0, s_a} + {1'b0, s_b} + {2'b0, s_cin};
            6'b000010: {s_cout, s_res} = {1'b0, s_a} + {1'b0, ~s_b} + {2'b0, s_cin};
            6'b000100: s_res = {s_a[0], s_a[1]};
            6'b001000: s_res = s_a & s_b;
            6'b010000: s_res = s_a | s_b;
            6'b100000: s_res = s_a ^ s_b;
            default: ;
        endcase
    end

    typedef struct {
        logic [5:0]  op;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        s;
        logic        err;
        int          lat;
        int          bp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, " result"}, 32'(tx_result), 32'd0);
        check({tag, " carry"}, 32'(tx_c), 32'd0);
        check({tag, " error"}, 32'(tx_err), 32'd0);
        check({tag, " zero"}, 32'(tx_z), 32'd1);
        check({tag, " sign"}, 32'(tx_s), 32'd0);
        check({tag, " slice_op"}, 32'(s_op), 32'd0);
        check({tag, " slice_ab"}, 32'({s_a, s_b}), 32'd0);
        check({tag, " slice_cin"}, 32'(s_cin), 32'd0);
    endtask

    task automatic do_op(input vec_t v, input int idx);
        logic [15:0] ra, rb, rr;
        logic        rc;
        int          n;
        string       t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        check({t, " ready_before"}, 32'(tx_ready), 32'd1);
        rx_valid = 1'b1;
        rx_op    = v.op;
        rx_cin   = v.cin;
        rx_a     = v.a;
        rx_b     = v.b;
        @(posedge clk);
        #1;
        // Scramble request inputs: only the accept edge may matter.
        rx_valid = 1'b0;
        rx_op    = 6'b000001;
        rx_cin   = ~v.cin;
        rx_a     = ~v.a;
        rx_b     = ~v.b;
        n  = 1;
        ra = v.a;
        rb = v.b;
        while (!tx_valid && n < 40) begin
            if (v.err) begin
                check({t, " slice_op_idle"}, 32'(s_op), 32'd0);
            end else begin
                check({t, " slice_op"}, 32'(s_op), 32'(v.op));
                check({t, " slice_a"}, 32'(s_a), 32'(ra[2*(n-1) +: 2]));
                check({t, " slice_b"}, 32'(s_b), 32'(rb[2*(n-1) +: 2]));
                if (n == 1) check({t, " slice_cin"}, 32'(s_cin), 32'(v.cin));
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({t, " latency"}, 32'(n), 32'(v.lat));
        check({t, " result"}, 32'(tx_result), 32'(v.res));
        check({t, " carry"}, 32'(tx_c), 32'(v.c));
        check({t, " zero"}, 32'(tx_z), 32'(v.z));
        check({t, " sign"}, 32'(tx_s), 32'(v.s));
        check({t, " error"}, 32'(tx_err), 32'(v.err));
        check({t, " ready_done"}, 32'(tx_ready), 32'd0);
        check({t, " slice_op_done"}, 32'(s_op), 32'd0);
        rr = tx_result;
        rc = tx_c;
        for (int i = 0; i < v.bp; i++) begin
            @(posedge clk);
            #1;
            check({t, " bp_valid"}, 32'(tx_valid), 32'd1);
            check({t, " bp_ready"}, 32'(tx_ready), 32'd0);
            check({t, " bp_result"}, 32'({tx_result, tx_c}), 32'({rr, rc}));
        end
        @(negedge clk);
        rx_ready = 1'b1;
        if (v.bp > 0) begin
            rx_valid = 1'b1;
            rx_op    = 6'b000001;
        end
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check({t, " hs_valid"}, 32'(tx_valid), 32'd0);
        check({t, " hs_ready"}, 32'(tx_ready), 32'd1);
        check({t, " hs_slice_op"}, 32'(s_op), 32'd0);
        rx_valid = 1'b0;
    endtask

    initial begin
        //         op         cin   a        b        res      c     z     s     err   lat bp
        vecs[0] = '{6'b000001, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0};
        vecs[1] = '{6'b000001, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9, 0};
        vecs[2] = '{6'b000001, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0};
        vecs[3] = '{6'b001000, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0};
        vecs[4] = '{6'b010000, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0};
        vecs[5] = '{6'b100000, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 5};
        vecs[6] = '{6'b000011, 1'b1, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[7] = '{6'b000010, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0};
        vecs[8] = '{6'b000000, 1'b0, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3};
        vecs[9] = '{6'b000100, 1'b0, 16'h8001, 16'h0000, 16'h4002, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_ready = 1'b0;
        rx_op    = 6'd0;
        rx_cin   = 1'b0;
        rx_a     = 16'd0;
        rx_b     = 16'd0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_op(vecs[i], i);

        // Reset while beat 3 is on the slice: everything must drop to reset values at once.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_op    = 6'b000001;
        rx_cin   = 1'b0;
        rx_a     = 16'hFFFF;
        rx_b     = 16'hFFFF;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun slice_a", 32'(s_a), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(vecs[0], 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu2_seq.md
# alu2_seq

Multi-cycle sequencer that executes one WIDTH-bit ALU operation by streaming operands two bits per cycle, LSB first, through a single external alu2 slice. It sits directly upstream and downstream of the slice: it drives the slice's operand, op and carry inputs, and collects the slice's 2-bit result and carry-out into a full-width result word. It reports final carry, zero and sign flags to the consumer over a valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width in bits; must be even and ≥ 4; BEATS = WIDTH/2
- rx_clk  input  1  clock, all state on rising edge
- rx_rst_n  input  1  reset, asynchronous assert, active-low
- rx_valid  input  1  request valid
- tx_ready  output  1  sequencer can accept a request
- rx_op  input  6  one-hot op select (bit0 add, 1 sub, 2 rot, 3 and, 4 or, 5 xor)
- rx_carryflag  input  1  carry into beat 0
- rx_operand0  input  WIDTH  operand A
- rx_operand1  input  WIDTH  operand B
- tx_valid  output  1  result valid
- rx_ready  input  1  consumer accepts result
- tx_result  output  WIDTH  assembled result
- tx_carryflag  output  1  carry-out of final beat
- tx_zeroflag  output  1  tx_result == 0
- tx_signflag  output  1  tx_result[WIDTH-1]
- tx_error  output  1  rx_op was not exactly one-hot
- tx_slice_op  output  6  op to slice
- tx_slice_carryflag  output  1  carry to slice
- tx_slice_operand0  output  2  A bits for current beat
- tx_slice_operand1  output  2  B bits for current beat
- rx_slice_result  input  2  slice result (combinational from slice inputs)
- rx_slice_carryflag  input  1  slice carry-out

## Operation
- States: IDLE, RUN, DONE.
- IDLE: tx_ready=1, tx_valid=0. On rx_valid&tx_ready: latch op, carry, both operands; clear result register and beat counter k. If rx_op is one-hot -> RUN; else -> DONE with result 0, carry 0, tx_error=1 (slice never driven).
- RUN: tx_ready=0. Per cycle, beat k drives tx_slice_op=latched op, tx_slice_operand0/1 = bits [2k+1:2k] of latched operands, tx_slice_carryflag = latched carry-in if k==0 else carry register. At clock edge: rx_slice_result stored into result bits [2k+1:2k]; rx_slice_carryflag stored into carry register; k increments. After beat k=BEATS-1 -> DONE.
- DONE: tx_valid=1, outputs stable until rx_ready. On tx_valid&rx_ready -> IDLE. No new request accepted in the same cycle as the result handshake (tx_ready rises the following cycle).
- Outside RUN: tx_slice_op=0, tx_slice_operand0/1=0, tx_slice_carryflag=0.
- Flags derived from registered result: tx_zeroflag = ~|tx_result, tx_signflag = tx_result[WIDTH-1]; valid only when tx_valid=1 but driven continuously.
- tx_error cleared on next accepted request.
- Beat counter width ceil(log2(BEATS)); no wrap beyond BEATS-1.

## Timing
- Reset (rx_rst_n low, any state, asynchronous): state IDLE, tx_ready=1 after release, tx_valid=0, tx_result=0, tx_carryflag=0, tx_error=0, tx_zeroflag=1, tx_signflag=0, slice drive outputs 0, k=0. Reset mid-RUN or mid-DONE discards the operation; no partial result is presented.
- Latency: request accepted at edge 0; beats occupy cycles 1..BEATS; tx_valid high from cycle BEATS+1. Illegal op: tx_valid high at cycle 1.
- Throughput: one operation per BEATS+2 cycles with rx_ready held high.
- Request inputs are sampled only at the accept edge; changes during RUN/DONE are ignored.
- Back-pressure: DONE holds indefinitely while rx_ready=0 with all outputs constant.

## Test plan
- Add, WIDTH=16: A=0x00FF, B=0x0001, carry-in 0 -> tx_result 0x0100, carry 0, zero 0, sign 0; tx_valid exactly 9 cycles after accept.
- Add overflow: A=0xFFFF, B=0x0001, carry-in 0 -> result 0x0000, carry 1, zero 1; then A=0x7FFF,B=0x0000,carry-in 1 -> 0x8000, sign 1.
- Logic ops: and/or/xor on A=0xF0F0, B=0xFF00 -> 0xF000 / 0xFFF0 / 0x0FF0, carry 0; per-beat tx_slice_operand0/1 match bit pairs LSB-first.
- Illegal op rx_op=6'b000011 -> tx_valid one cycle after accept, tx_error 1, result 0, tx_slice_op stays 0 throughout.
- Back-pressure: hold rx_ready=0 for 5 cycles in DONE -> outputs constant, tx_ready 0; assert rx_ready -> IDLE next cycle, tx_ready 1, rx_valid in handshake cycle not accepted.
- Reset during RUN at beat 3 -> all outputs at reset values immediately; next request completes normally with correct result.
